// File: rtl/urisc_pkg.sv
// Shared definitions for the uRISC pipeline: architectural sizes and the
// writeback status encoding.
package urisc_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = $clog2(NUM_REGS);

  // Machine status seen by writeback. HALTED and ERROR are sticky until reset.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    ERROR  = 2'd2
  } wb_state_t;

endpackage : urisc_pkg

// File: rtl/wb_reg_file.sv
// Architectural register file: one synchronous write port, two combinational
// read ports with write-through bypass so decode sees a same-cycle commit.
module reg_file #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,        // synchronous, active-low
  input  logic                        i_we,       // already commit-qualified
  input  logic [$clog2(NUM_REGS)-1:0] i_waddr,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic [$clog2(NUM_REGS)-1:0] i_raddr_a,
  input  logic [$clog2(NUM_REGS)-1:0] i_raddr_b,
  output logic [DATA_W-1:0]           o_rdata_a,
  output logic [DATA_W-1:0]           o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_byp_a;
  logic              w_byp_b;

  // Register array: cleared on reset, otherwise written by the qualified enable.
  // NOTE: every entry is reset because software may read any register before
  // writing it; this forces flops rather than RAM macros, which is acceptable
  // at eight entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // The write enable arrives gated by reset, so the bypass is dead while rst=0.
  assign w_byp_a = i_we && (i_raddr_a == i_waddr);
  assign w_byp_b = i_we && (i_raddr_b == i_waddr);

  // Read ports: array contents, overridden by the in-flight write on a match.
  always_comb begin
    o_rdata_a = r_regs[i_raddr_a];
    o_rdata_b = r_regs[i_raddr_b];
    if (w_byp_a) o_rdata_a = i_wdata;
    if (w_byp_b) o_rdata_b = i_wdata;
  end

endmodule : reg_file

// File: rtl/wb.sv
// Writeback stage: commits the p5 destination bundle to the register file,
// tracks run/halted/error status, counts retired instructions (saturating)
// and records the PC of the last retired instruction.
module wb #(
  parameter int NUM_REGS = urisc_pkg::NUM_REGS,
  parameter int DATA_W   = urisc_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,   // synchronous, active-low
  input  logic [DATA_W-1:0]           pc_p5,
  input  logic                        instr_valid_memwb_p5,
  input  logic [DATA_W-1:0]           dest_reg_value_memwb_p5,
  input  logic [$clog2(NUM_REGS)-1:0] dest_reg_index_memwb_p5,
  input  logic                        dest_reg_write_valid_memwb_p5,
  input  logic                        err_memwb_p5,
  input  logic                        halt_memwb_p5,
  input  logic [$clog2(NUM_REGS)-1:0] rd_index_a_p2,
  input  logic [$clog2(NUM_REGS)-1:0] rd_index_b_p2,
  output logic [DATA_W-1:0]           rd_data_a_p2,
  output logic [DATA_W-1:0]           rd_data_b_p2,
  output logic                        halted,
  output logic                        err_latched,
  output logic [DATA_W-1:0]           retired_count,
  output logic [DATA_W-1:0]           last_pc_p6
);

  import urisc_pkg::*;

  wb_state_t         r_state;
  wb_state_t         w_state_next;
  logic              w_commit;
  logic              w_rf_we;
  logic [DATA_W-1:0] r_retired_count;
  logic [DATA_W-1:0] r_last_pc;

  // An instruction commits only while running and fault-free; reset kills it
  // so a colliding write is neither stored nor bypassed.
  assign w_commit = rst && instr_valid_memwb_p5 && (r_state == RUN) && !err_memwb_p5;
  assign w_rf_we  = w_commit && dest_reg_write_valid_memwb_p5;

  // Status register; reset returns the machine to RUN.
  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_state_next;
  end

  // Next-state logic: ERROR outranks HALT; both terminal states hold.
  // NOTE: the default assignment up front keeps this purely combinational
  // on every path through the case.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (instr_valid_memwb_p5 && err_memwb_p5)       w_state_next = ERROR;
        else if (instr_valid_memwb_p5 && halt_memwb_p5) w_state_next = HALTED;
      end
      HALTED:  w_state_next = HALTED;
      ERROR:   w_state_next = ERROR;
      default: w_state_next = ERROR;
    endcase
  end

  // Retire bookkeeping: saturating count and PC of the last committed instruction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_retired_count <= '0;
      r_last_pc       <= '0;
    end else if (w_commit) begin
      if (!(&r_retired_count)) r_retired_count <= r_retired_count + DATA_W'(1);
      r_last_pc <= pc_p5;
    end
  end

  reg_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (dest_reg_index_memwb_p5),
    .i_wdata   (dest_reg_value_memwb_p5),
    .i_raddr_a (rd_index_a_p2),
    .i_raddr_b (rd_index_b_p2),
    .o_rdata_a (rd_data_a_p2),
    .o_rdata_b (rd_data_b_p2)
  );

  assign halted        = (r_state == HALTED);
  assign err_latched   = (r_state == ERROR);
  assign retired_count = r_retired_count;
  assign last_pc_p6    = r_last_pc;

endmodule : wb

// File: tb/tb_wb.sv
// Scoreboard bench for wb: stimulus queues expected observations tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_p5;
  logic        instr_valid;
  logic [15:0] dest_value;
  logic [2:0]  dest_index;
  logic        dest_we;
  logic        err_in;
  logic        halt_in;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic        halted;
  logic        err_latched;
  logic [15:0] retired_count;
  logic [15:0] last_pc;

  always #5 clk = ~clk;

  wb dut (
    .clk                           (clk),
    .rst                           (rst),
    .pc_p5                         (pc_p5),
    .instr_valid_memwb_p5          (instr_valid),
    .dest_reg_value_memwb_p5       (dest_value),
    .dest_reg_index_memwb_p5       (dest_index),
    .dest_reg_write_valid_memwb_p5 (dest_we),
    .err_memwb_p5                  (err_in),
    .halt_memwb_p5                 (halt_in),
    .rd_index_a_p2                 (ra),
    .rd_index_b_p2                 (rb),
    .rd_data_a_p2                  (rd_a),
    .rd_data_b_p2                  (rd_b),
    .halted                        (halted),
    .err_latched                   (err_latched),
    .retired_count                 (retired_count),
    .last_pc_p6                    (last_pc)
  );

  typedef enum {OBS_RDA, OBS_RDB, OBS_HALTED, OBS_ERR, OBS_CNT, OBS_LASTPC} obs_t;

  typedef struct {
    int          cyc;
    obs_t        obs;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] observe(input obs_t o);
    case (o)
      OBS_RDA:    return rd_a;
      OBS_RDB:    return rd_b;
      OBS_HALTED: return {15'd0, halted};
      OBS_ERR:    return {15'd0, err_latched};
      OBS_CNT:    return retired_count;
      default:    return last_pc;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = observe(e.obs);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)", e.name, act, e.val, e.cyc);
      end
    end
  end

  task automatic check(input obs_t o, input logic [15:0] v, input string n);
    exp_t e;
    e.cyc  = cyc;
    e.obs  = o;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] idx,
                       input logic [15:0] val, input logic e, input logic h,
                       input logic [15:0] pc);
    instr_valid = v;
    dest_we     = we;
    dest_index  = idx;
    dest_value  = val;
    err_in      = e;
    halt_in     = h;
    pc_p5       = pc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    ra = 3'd0;
    rb = 3'd0;

    // Reset held for two cycles.
    tick();
    tick();
    check(OBS_RDA,    16'h0000, "rst_rd_a");
    check(OBS_RDB,    16'h0000, "rst_rd_b");
    check(OBS_CNT,    16'h0000, "rst_count");
    check(OBS_HALTED, 16'h0000, "rst_halted");
    check(OBS_ERR,    16'h0000, "rst_err");
    check(OBS_LASTPC, 16'h0000, "rst_last_pc");
    tick();
    rst = 1'b1;

    // Write R3, read through bypass then from the array.
    drive(1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 16'h0010);
    ra = 3'd3;
    rb = 3'd2;
    check(OBS_RDA, 16'hBEEF, "bypass_a");
    check(OBS_RDB, 16'h0000, "bypass_b_r2");
    check(OBS_CNT, 16'h0000, "count_before_edge");
    tick();
    idle();
    check(OBS_RDA,    16'hBEEF, "array_a");
    check(OBS_RDB,    16'h0000, "array_b_r2");
    check(OBS_CNT,    16'h0001, "count_after_write");
    check(OBS_LASTPC, 16'h0010, "last_pc_write");
    tick();

    // Bubble carrying a stray write must do nothing.
    drive(1'b0, 1'b1, 3'd2, 16'hDEAD, 1'b0, 1'b0, 16'h0099);
    check(OBS_RDB, 16'h0000, "bubble_no_bypass");
    tick();
    idle();
    check(OBS_RDB,    16'h0000, "bubble_no_write");
    check(OBS_CNT,    16'h0001, "bubble_no_retire");
    check(OBS_LASTPC, 16'h0010, "bubble_last_pc");
    tick();

    // Both ports on the same index.
    rb = 3'd3;
    check(OBS_RDA, 16'hBEEF, "same_idx_a");
    check(OBS_RDB, 16'hBEEF, "same_idx_b");
    tick();

    // Halt: three writes, HALT writing R1, then a write that must be ignored.
    do_reset();
    drive(1'b1, 1'b1, 3'd4, 16'h0101, 1'b0, 1'b0, 16'h0020);
    tick();
    drive(1'b1, 1'b1, 3'd6, 16'h0606, 1'b0, 1'b0, 16'h0022);
    tick();
    drive(1'b1, 1'b1, 3'd7, 16'h0707, 1'b0, 1'b0, 16'h0024);
    tick();
    drive(1'b1, 1'b1, 3'd1, 16'h0042, 1'b0, 1'b1, 16'h0026);
    ra = 3'd1;
    rb = 3'd7;
    check(OBS_RDA,    16'h0042, "halt_bypass");
    check(OBS_RDB,    16'h0707, "halt_r7_array");
    check(OBS_HALTED, 16'h0000, "halt_not_yet");
    check(OBS_CNT,    16'h0003, "halt_count_pre");
    tick();
    drive(1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b0, 16'h0028);
    check(OBS_HALTED, 16'h0001, "halted_set");
    check(OBS_CNT,    16'h0004, "halt_count");
    check(OBS_LASTPC, 16'h0026, "halt_last_pc");
    check(OBS_RDA,    16'h0042, "halted_no_bypass");
    tick();
    idle();
    check(OBS_RDA,    16'h0042, "halted_r1_kept");
    check(OBS_CNT,    16'h0004, "halted_count_hold");
    check(OBS_LASTPC, 16'h0026, "halted_last_pc_hold");
    check(OBS_ERR,    16'h0000, "halted_no_err");
    tick();

    // Error outranks halt; the faulting write is dropped.
    do_reset();
    drive(1'b1, 1'b1, 3'd5, 16'h5555, 1'b0, 1'b0, 16'h0030);
    tick();
    drive(1'b1, 1'b1, 3'd5, 16'h7777, 1'b1, 1'b1, 16'h0032);
    ra = 3'd5;
    rb = 3'd5;
    check(OBS_RDA, 16'h5555, "err_no_bypass");
    check(OBS_ERR, 16'h0000, "err_not_yet");
    tick();
    drive(1'b1, 1'b1, 3'd5, 16'h9999, 1'b0, 1'b0, 16'h0034);
    check(OBS_ERR,    16'h0001, "err_latched");
    check(OBS_HALTED, 16'h0000, "err_beats_halt");
    check(OBS_CNT,    16'h0001, "err_count_hold");
    check(OBS_LASTPC, 16'h0030, "err_last_pc_hold");
    check(OBS_RDA,    16'h5555, "err_state_no_bypass");
    tick();
    idle();
    check(OBS_RDA, 16'h5555, "err_r5_kept");
    tick();

    // Reset from ERROR while a valid write is presented.
    rst = 1'b0;
    drive(1'b1, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b0, 16'h0040);
    ra = 3'd2;
    rb = 3'd5;
    check(OBS_RDA, 16'h0000, "rst_kills_bypass");
    tick();
    rst = 1'b1;
    idle();
    check(OBS_RDA,    16'h0000, "rst_no_write");
    check(OBS_RDB,    16'h0000, "rst_r5_cleared");
    check(OBS_ERR,    16'h0000, "rst_err_cleared");
    check(OBS_HALTED, 16'h0000, "rst_halted_clear");
    check(OBS_CNT,    16'h0000, "rst_count_cleared");
    check(OBS_LASTPC, 16'h0000, "rst_last_pc_cleared");
    tick();
    drive(1'b1, 1'b1, 3'd0, 16'hAAAA, 1'b0, 1'b0, 16'h0044);
    ra = 3'd0;
    check(OBS_RDA, 16'hAAAA, "run_after_rst");
    tick();
    idle();
    check(OBS_RDA,    16'hAAAA, "r0_writable");
    check(OBS_CNT,    16'h0001, "count_after_rst");
    check(OBS_LASTPC, 16'h0044, "last_pc_after_rst");
    tick();

    // Saturation: 65,537 retires, then a few more.
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'(i) ^ 16'h5A5A);
      if (i == 65534) check(OBS_CNT, 16'hFFFE, "sat_fffe");
      if (i == 65535) check(OBS_CNT, 16'hFFFF, "sat_reach");
      tick();
    end
    idle();
    check(OBS_CNT,    16'hFFFF, "sat_no_wrap");
    check(OBS_LASTPC, 16'h5A5A, "sat_last_pc");
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h1234);
      tick();
    end
    idle();
    check(OBS_CNT,    16'hFFFF, "sat_hold");
    check(OBS_LASTPC, 16'h1234, "sat_last_pc_moves");
    tick();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb

// File: doc/wb.md
# wb

Writeback stage of the 16-bit uRISC pipeline, directly downstream of the memory stage. Consumes the p5 destination-register bundle, commits it to an 8-entry architectural register file, and serves two same-cycle-bypassed read ports to decode. Also tracks machine status (run/halted/error), a saturating retired-instruction counter, and the PC of the last retired instruction.

## Interface
Parameters:
- NUM_REGS, 8, architectural register count; the index width is log2(NUM_REGS).
- DATA_W, 16, register and PC width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset. Synchronous to clk, active-low: the block is held in reset while rst is 0.
- pc_p5  in  16  PC of the instruction in writeback.
- instr_valid_memwb_p5  in  1  a real instruction is in writeback; 0 means a bubble.
- dest_reg_value_memwb_p5  in  16  value to commit.
- dest_reg_index_memwb_p5  in  3  destination index.
- dest_reg_write_valid_memwb_p5  in  1  the instruction writes a register.
- err_memwb_p5  in  1  the instruction faulted in memory.
- halt_memwb_p5  in  1  the instruction is HALT.
- rd_index_a_p2, rd_index_b_p2  in  3 each  decode read indices.
- rd_data_a_p2, rd_data_b_p2  out  16 each  read data (combinational).
- halted  out  1  status is HALTED.
- err_latched  out  1  status is ERROR.
- retired_count  out  16  number of retired instructions, saturating.
- last_pc_p6  out  16  PC of the most recent retired instruction.

## Operation
- Status FSM states: RUN, HALTED, ERROR. Reset state is RUN.
- A commit qualifier is defined as `commit = instr_valid & state==RUN & ~err`.
- Register write:
  - The register at dest index takes the dest value on posedge when commit & write_valid.
  - No register is hardwired to zero.
- Retire:
  - When commit is 1, retired_count increments and last_pc_p6 takes pc_p5.
  - retired_count saturates at 0xFFFF; it never wraps.
- Transitions:
  - RUN -> ERROR when instr_valid & err. That instruction does not write, does not retire, and does not update last_pc.
  - RUN -> HALTED when instr_valid & halt & ~err. The HALT instruction itself retires, and its write, if any, commits.
  - When err and halt are both set, ERROR wins.
  - HALTED and ERROR are terminal until reset. All inputs are ignored in these states; only the read ports keep working.
- Bubbles (instr_valid=0) change nothing.
- Read ports:
  - Each port returns regs[index].
  - If commit & write_valid and the read index equals the dest index, the port returns dest_reg_value_memwb_p5 instead (write-through bypass).
  - Both ports may read the same index.

## Timing
- Reset values, applied on posedge while rst=0, override everything:
  - all registers 0x0000
  - state RUN
  - halted 0, err_latched 0
  - retired_count 0x0000
  - last_pc_p6 0x0000
  - Read ports show 0x0000 once reset is applied. The bypass is inactive while rst=0.
- A write is visible on the read ports in the same cycle through the bypass, and from the register array on the following cycle.
- halted, err_latched, retired_count and last_pc_p6 are registered. Each is visible the cycle after the causing edge.
- Reset asserted in the same cycle as a valid commit: reset wins; nothing is written.
- There is no backpressure. One instruction per cycle is accepted.

## Structure
- Shared package `urisc_pkg` holds:
  - DATA_W, NUM_REGS and REG_IDX_W constants
  - `wb_state_t` enum {RUN, HALTED, ERROR}
- Sub-module `reg_file` contains:
  - the register array
  - synchronous write with active-low synchronous reset
  - two combinational read ports with bypass
  - wb instantiates it and drives it with the commit-qualified write enable.
- The status FSM, retire counter and last_pc register stay in wb.

## Test plan
- Reset: hold rst=0 for 2 cycles -> both read ports show 0x0000, retired_count=0, halted=0, err_latched=0.
- Write then read:
  - Stimulus: commit R3=0xBEEF while rd_index_a=3.
  - Same cycle: rd_data_a=0xBEEF through the bypass.
  - Next cycle, valid=0: rd_data_a=0xBEEF from the array.
  - Throughout: rd_data_b reading R2 = 0x0000.
- Halt:
  - Stimulus: retire 3 writes, then HALT writing R1=0x0042, then a valid write R1=0x1111.
  - Required: retired_count=4, halted=1, R1=0x0042, last_pc = HALT's PC.
- Error priority:
  - Stimulus: err=1 and halt=1 on a valid instruction with write_valid R5=0x7777.
  - Required: err_latched=1, halted=0, R5 unchanged, retired_count unchanged.
- Saturation: force 65,537 valid retires -> retired_count=0xFFFF and stays there.
- Reset mid-run:
  - Stimulus: from ERROR with registers nonzero, assert rst=0 for 1 cycle while a valid write is presented.
  - Required: state RUN, all registers 0, no write committed.
